// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: control-word bit layout, opcodes and sequencer states.
package sap1_pkg;

  localparam int CONTROL_WORD_WIDTH = 17;

  typedef logic [CONTROL_WORD_WIDTH-1:0] control_word_t;

  localparam control_word_t c_HLT = control_word_t'(1) << 16;
  localparam control_word_t c_MI  = control_word_t'(1) << 15;
  localparam control_word_t c_RI  = control_word_t'(1) << 14;
  localparam control_word_t c_RO  = control_word_t'(1) << 13;
  localparam control_word_t c_IO  = control_word_t'(1) << 12;
  localparam control_word_t c_II  = control_word_t'(1) << 11;
  localparam control_word_t c_AI  = control_word_t'(1) << 10;
  localparam control_word_t c_AO  = control_word_t'(1) << 9;
  localparam control_word_t c_SO  = control_word_t'(1) << 8;
  localparam control_word_t c_SU  = control_word_t'(1) << 7;
  localparam control_word_t c_BI  = control_word_t'(1) << 6;
  localparam control_word_t c_OI  = control_word_t'(1) << 5;
  localparam control_word_t c_CE  = control_word_t'(1) << 4;
  localparam control_word_t c_CO  = control_word_t'(1) << 3;
  localparam control_word_t c_J   = control_word_t'(1) << 2;
  localparam control_word_t c_EL  = control_word_t'(1) << 1;
  localparam control_word_t c_ADV = control_word_t'(1);

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUBI = 4'h6;
  localparam logic [3:0] OP_STA  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JIZ  = 4'h9;
  localparam logic [3:0] OP_JIC  = 4'hA;
  localparam logic [3:0] OP_JIO  = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_TRAP   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: (opcode, step, latched flags) -> control word.
// Unimplemented opcodes yield an all-zero word past fetch with implemented = 0.
module microcode_rom
  import sap1_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int STEP_WIDTH        = 3
) (
  input  logic [INSTRUCTION_WIDTH-1:0] opcode,
  input  logic [STEP_WIDTH-1:0]        step,
  input  logic                         zero,
  input  logic                         carry,
  input  logic                         odd,
  output control_word_t                word,
  output logic                         implemented
);

  logic [3:0]  op4;
  logic        high_ok;
  logic [31:0] s;

  assign op4 = opcode[3:0];
  assign s   = 32'(step);

  // Opcodes with any bit above the classic 4-bit field set are never implemented
  if (INSTRUCTION_WIDTH > 4) begin : g_wide
    assign high_ok = ~|opcode[INSTRUCTION_WIDTH-1:4];
  end else begin : g_narrow
    assign high_ok = 1'b1;
  end

  // Fetch is opcode-independent; decode steps start at 2
  always_comb begin
    word        = '0;
    implemented = 1'b0;
    case (op4)
      OP_LDA, OP_ADD, OP_SUB, OP_LDI, OP_ADDI, OP_SUBI, OP_STA,
      OP_JMP, OP_JIZ, OP_JIC, OP_JIO, OP_OUT, OP_HLT: implemented = high_ok;
      default: implemented = 1'b0;
    endcase

    if (s == 0) begin
      word = c_MI | c_CO;
    end else if (s == 1) begin
      word = c_RO | c_II | c_CE;
    end else if (implemented) begin
      case (op4)
        OP_LDA: case (s)
          2: word = c_IO | c_MI;
          3: word = c_RO | c_AI | c_ADV;
          default: word = '0;
        endcase
        OP_ADD: case (s)
          2: word = c_IO | c_MI;
          3: word = c_RO | c_BI;
          4: word = c_SO | c_AI | c_EL | c_ADV;
          default: word = '0;
        endcase
        OP_SUB: case (s)
          2: word = c_IO | c_MI;
          3: word = c_RO | c_BI;
          4: word = c_SO | c_SU | c_AI | c_EL | c_ADV;
          default: word = '0;
        endcase
        OP_LDI:  word = (s == 2) ? (c_IO | c_AI | c_ADV) : '0;
        OP_ADDI: case (s)
          2: word = c_IO | c_BI;
          3: word = c_SO | c_AI | c_EL | c_ADV;
          default: word = '0;
        endcase
        OP_SUBI: case (s)
          2: word = c_IO | c_BI;
          3: word = c_SO | c_SU | c_AI | c_EL | c_ADV;
          default: word = '0;
        endcase
        OP_STA: case (s)
          2: word = c_IO | c_MI;
          3: word = c_AO | c_RI | c_ADV;
          default: word = '0;
        endcase
        OP_JMP: word = (s == 2) ? (c_IO | c_J | c_ADV) : '0;
        OP_JIZ: word = (s == 2) ? (zero  ? (c_IO | c_J | c_ADV) : c_ADV) : '0;
        OP_JIC: word = (s == 2) ? (carry ? (c_IO | c_J | c_ADV) : c_ADV) : '0;
        OP_JIO: word = (s == 2) ? (odd   ? (c_IO | c_J | c_ADV) : c_ADV) : '0;
        OP_OUT: word = (s == 2) ? (c_AO | c_OI | c_ADV) : '0;
        OP_HLT: word = (s == 2) ? (c_HLT | c_ADV) : '0;
        default: word = '0;
      endcase
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// SAP-1 microcode sequencer: step counter, latched ALU flags, RUN/HALTED/TRAP state.
// Optional build macro SAP1_ILLEGAL_TRAP_EN: unimplemented opcodes and step
// overflow trap (sticky o_illegal) instead of executing as NOP / forced advance.
module microcode_sequencer
  import sap1_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int INSTRUCTION_STEPS = 8,
  parameter int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [INSTRUCTION_WIDTH-1:0]  i_instruction,
  input  logic                          i_zero,
  input  logic                          i_carry,
  input  logic                          i_odd,
  input  logic                          i_stall,
  input  logic                          i_resume,
  output logic [CONTROL_WORD_WIDTH-1:0] o_control_word,
  output logic [STEP_WIDTH-1:0]         o_step,
  output logic                          o_halted,
  output logic                          o_illegal
);

  seq_state_t            state;
  logic [STEP_WIDTH-1:0] step;
  logic                  flag_zero, flag_carry, flag_odd;
  control_word_t         rom_word, run_word, word;
  logic                  implemented, step_two, last_step, enter_trap;

  microcode_rom #(
    .INSTRUCTION_WIDTH(INSTRUCTION_WIDTH),
    .STEP_WIDTH       (STEP_WIDTH)
  ) u_rom (
    .opcode     (i_instruction),
    .step       (step),
    .zero       (flag_zero),
    .carry      (flag_carry),
    .odd        (flag_odd),
    .word       (rom_word),
    .implemented(implemented)
  );

  assign step_two  = (step == STEP_WIDTH'(2));
  assign last_step = (step == STEP_WIDTH'(INSTRUCTION_STEPS - 1));

`ifdef SAP1_ILLEGAL_TRAP_EN
  // ROM already gives 0 past fetch for unimplemented opcodes; trap on decode or overflow
  assign enter_trap = (step_two && !implemented) || (last_step && !(|(rom_word & c_ADV)));
  assign run_word   = rom_word;
  assign o_illegal  = (state == ST_TRAP);
`else
  // Unimplemented opcode becomes a one-step NOP; a sequence running off the end is forced home
  logic _unused_last;
  assign _unused_last = 1'b0;
  assign enter_trap   = 1'b0;
  always_comb begin
    run_word = rom_word;
    if (step_two && !implemented) run_word = c_ADV;
    if (last_step) run_word = run_word | c_ADV;
  end
  assign o_illegal = 1'b0;
`endif

  // Only RUN drives a live word; HALTED and TRAP output all zeros
  always_comb begin
    word = '0;
    if (state == ST_RUN) word = run_word;
  end

  assign o_control_word = word;
  assign o_step         = step;
  assign o_halted       = (state == ST_HALTED);

  // State, step and flag registers; a stall freezes all of them
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_RUN;
      step       <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_odd   <= 1'b0;
    end else if (!i_stall) begin
      case (state)
        ST_RUN: begin
          if (|(word & c_EL)) begin
            flag_zero  <= i_zero;
            flag_carry <= i_carry;
            flag_odd   <= i_odd;
          end
          if (enter_trap) begin
            state <= ST_TRAP;
          end else if (|(word & c_HLT)) begin
            state <= ST_HALTED;
            step  <= '0;
          end else if (|(word & c_ADV)) begin
            step <= '0;
          end else begin
            step <= step + STEP_WIDTH'(1);
          end
        end
        ST_HALTED: begin
          if (i_resume) begin
            state <= ST_RUN;
            step  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed vectors with literal
// expectations plus a per-cycle comparison against an instruction-level model.
module tb_microcode_sequencer;

  localparam logic [16:0] B_HLT = 17'h10000;
  localparam logic [16:0] B_MI  = 17'h08000;
  localparam logic [16:0] B_RI  = 17'h04000;
  localparam logic [16:0] B_RO  = 17'h02000;
  localparam logic [16:0] B_IO  = 17'h01000;
  localparam logic [16:0] B_II  = 17'h00800;
  localparam logic [16:0] B_AI  = 17'h00400;
  localparam logic [16:0] B_AO  = 17'h00200;
  localparam logic [16:0] B_SO  = 17'h00100;
  localparam logic [16:0] B_SU  = 17'h00080;
  localparam logic [16:0] B_BI  = 17'h00040;
  localparam logic [16:0] B_OI  = 17'h00020;
  localparam logic [16:0] B_CE  = 17'h00010;
  localparam logic [16:0] B_CO  = 17'h00008;
  localparam logic [16:0] B_J   = 17'h00004;
  localparam logic [16:0] B_EL  = 17'h00002;
  localparam logic [16:0] B_ADV = 17'h00001;

  logic        clk, rst_n;
  logic [3:0]  instr;
  logic        zero, carry, odd, stall, resume;
  logic [16:0] cw;
  logic [2:0]  step;
  logic        halted, illegal;

  int checks = 0;
  int failures = 0;

  microcode_sequencer #(
    .INSTRUCTION_WIDTH(4),
    .INSTRUCTION_STEPS(8)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_instruction (instr),
    .i_zero        (zero),
    .i_carry       (carry),
    .i_odd         (odd),
    .i_stall       (stall),
    .i_resume      (resume),
    .o_control_word(cw),
    .o_step        (step),
    .o_halted      (halted),
    .o_illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Micro-ops after fetch, without the end-of-instruction marker
  function automatic logic [16:0] body_word(int op, int k, bit z, bit c, bit o);
    logic [16:0] b [0:2];
    for (int i = 0; i < 3; i++) b[i] = 17'h0;
    case (op)
      1:  begin b[0] = B_IO | B_MI; b[1] = B_RO | B_AI; end
      2:  begin b[0] = B_IO | B_MI; b[1] = B_RO | B_BI; b[2] = B_SO | B_AI | B_EL; end
      3:  begin b[0] = B_IO | B_MI; b[1] = B_RO | B_BI; b[2] = B_SO | B_SU | B_AI | B_EL; end
      4:  b[0] = B_IO | B_AI;
      5:  begin b[0] = B_IO | B_BI; b[1] = B_SO | B_AI | B_EL; end
      6:  begin b[0] = B_IO | B_BI; b[1] = B_SO | B_SU | B_AI | B_EL; end
      7:  begin b[0] = B_IO | B_MI; b[1] = B_AO | B_RI; end
      8:  b[0] = B_IO | B_J;
      9:  b[0] = z ? (B_IO | B_J) : 17'h0;
      10: b[0] = c ? (B_IO | B_J) : 17'h0;
      11: b[0] = o ? (B_IO | B_J) : 17'h0;
      14: b[0] = B_AO | B_OI;
      15: b[0] = B_HLT;
      default: ;
    endcase
    return (k >= 0 && k < 3) ? b[k] : 17'h0;
  endfunction

  function automatic int body_len(int op);
    case (op)
      1, 5, 6, 7:               return 2;
      2, 3:                     return 3;
      4, 8, 9, 10, 11, 14, 15:  return 1;
      default:                  return 0;
    endcase
  endfunction

  function automatic int seq_len(int op);
    return 2 + ((body_len(op) == 0) ? 1 : body_len(op));
  endfunction

  function automatic logic [16:0] model_word(int op, int st, bit z, bit c, bit o, bit h, bit t);
    int n;
    n = body_len(op);
    if (h || t) return 17'h0;
    if (st == 0) return B_MI | B_CO;
    if (st == 1) return B_RO | B_II | B_CE;
    if (n == 0) begin
`ifdef SAP1_ILLEGAL_TRAP_EN
      return 17'h0;
`else
      return (st == 2) ? B_ADV : 17'h0;
`endif
    end
    if (st - 2 < n) return body_word(op, st - 2, z, c, o) | ((st - 2 == n - 1) ? B_ADV : 17'h0);
    return 17'h0;
  endfunction

  // Instruction-level model: position within the opcode's sequence, halt/trap, latched flags
  int m_step;
  bit m_halted, m_trap, m_z, m_c, m_o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_step <= 0; m_halted <= 0; m_trap <= 0; m_z <= 0; m_c <= 0; m_o <= 0;
    end else if (!stall) begin
      if (m_trap) begin
      end else if (m_halted) begin
        if (resume) begin m_halted <= 0; m_step <= 0; end
      end else begin
        if ((model_word(int'(instr), m_step, m_z, m_c, m_o, 0, 0) & B_EL) != 17'h0) begin
          m_z <= zero; m_c <= carry; m_o <= odd;
        end
`ifdef SAP1_ILLEGAL_TRAP_EN
        if (body_len(int'(instr)) == 0 && m_step == 2) m_trap <= 1;
        else
`endif
        if (int'(instr) == 15 && m_step == 2) begin m_halted <= 1; m_step <= 0; end
        else if (m_step == seq_len(int'(instr)) - 1) m_step <= 0;
        else m_step <= m_step + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_cw", 32'(cw), 32'(model_word(int'(instr), m_step, m_z, m_c, m_o, m_halted, m_trap)));
      check("model_step", 32'(step), 32'(m_step));
      check("model_halted", 32'(halted), 32'(m_halted));
      check("model_illegal", 32'(illegal), 32'(m_trap));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n = 0; instr = 4'h0; zero = 0; carry = 0; odd = 0; stall = 0; resume = 0;
    ticks(2);
    check("rst_cw", 32'(cw), 32'h08008);
    check("rst_step", 32'(step), 0);
    rst_n = 1;
    check("rst_halted", 32'(halted), 0);
    check("rst_illegal", 32'(illegal), 0);

    // LDA: fetch, fetch, address, load
    instr = 4'h1;
    check("lda_s0", 32'(cw), 32'h08008);
    tick(); check("lda_s1", 32'(cw), 32'h02810); check("lda_st1", 32'(step), 1);
    tick(); check("lda_s2", 32'(cw), 32'h09000); check("lda_st2", 32'(step), 2);
    tick(); check("lda_s3", 32'(cw), 32'h02401); check("lda_st3", 32'(step), 3);
    tick(); check("lda_end", 32'(step), 0);

    // ADD latches zero=1, JIZ then jumps
    instr = 4'h2;
    ticks(4); check("add_s4", 32'(cw), 32'h00503);
    zero = 1; tick(); zero = 0;
    instr = 4'h9; ticks(2); check("jiz_taken", 32'(cw), 32'h01005);
    tick();
    // ADD latches zero=0, JIZ falls through
    instr = 4'h2; ticks(4); tick();
    instr = 4'h9; ticks(2); check("jiz_not_taken", 32'(cw), 32'h00001);
    tick();

    // Stall three cycles at LDA step 2
    instr = 4'h1; ticks(2);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      check("stall_step", 32'(step), 2);
      check("stall_cw", 32'(cw), 32'h09000);
      tick();
    end
    stall = 0;
    check("stall_release", 32'(step), 2);
    tick(); check("stall_s3", 32'(cw), 32'h02401);
    tick(); check("stall_end", 32'(step), 0);

    // HLT, stall beats resume, then resume
    instr = 4'hF; ticks(2);
    check("hlt_s2", 32'(cw), 32'h10001);
    tick(); check("hlt_halted", 32'(halted), 1); check("hlt_cw", 32'(cw), 0);
    stall = 1; resume = 1; tick();
    check("hlt_stall_wins", 32'(halted), 1);
    stall = 0; tick(); resume = 0;
    instr = 4'hC;
    check("resume_halted", 32'(halted), 0);
    check("resume_step", 32'(step), 0);
    check("resume_cw", 32'(cw), 32'h08008);

    // Unimplemented opcode C
    ticks(2);
`ifdef SAP1_ILLEGAL_TRAP_EN
    check("opc_trap_s2", 32'(cw), 0);
    tick(); check("opc_illegal", 32'(illegal), 1); check("opc_trap_cw", 32'(cw), 0);
    tick(); check("opc_sticky", 32'(illegal), 1);
    rst_n = 0; tick(); rst_n = 1;
    check("opc_reset_clear", 32'(illegal), 0);
`else
    check("opc_nop_s2", 32'(cw), 32'h00001);
    tick(); check("opc_nop_end", 32'(step), 0);
`endif

    // Latch all flags, confirm carry via JIC, then reset mid-ADD clears them
    instr = 4'h2; zero = 1; carry = 1; odd = 1;
    ticks(5);
    zero = 0; carry = 0; odd = 0;
    instr = 4'hA; ticks(2); check("jic_taken", 32'(cw), 32'h01005);
    tick();
    instr = 4'h2; ticks(3);
    check("add_mid_step", 32'(step), 3);
    #2; rst_n = 0; #1;
    check("async_rst_step", 32'(step), 0);
    check("async_rst_cw", 32'(cw), 32'h08008);
    check("async_rst_halted", 32'(halted), 0);
    tick(); rst_n = 1;
    instr = 4'h9; ticks(2); check("rst_flag_z", 32'(cw), 32'h00001); tick();
    instr = 4'hA; ticks(2); check("rst_flag_c", 32'(cw), 32'h00001); tick();
    instr = 4'hB; ticks(2); check("rst_flag_o", 32'(cw), 32'h00001); tick();

    // Sweep opcodes against the model with varying flag inputs
    for (int op = 0; op < 15; op++) begin
`ifdef SAP1_ILLEGAL_TRAP_EN
      if (op == 0 || op == 12 || op == 13) continue;
`endif
      instr = 4'(op);
      zero = op[0]; carry = op[1]; odd = ~op[2];
      tick();
      for (int t = 0; t < 12; t++) begin
        if (step == 0) break;
        stall = (op == 6 && t < 2);
        tick();
      end
      stall = 0;
      check("sweep_return", 32'(step), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
